// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores to TXDATA queue bytes into a small FIFO. A baud-timed FSM
// serialises them on tx. Loads from STATUS return FIFO/transmitter state.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   mem_addr, mem_wdata  address / store data from the EX/MEM register
//   mem_MemWr            store strobe (one cycle per store)
//   mem_MemRead          load strobe (one cycle per load)
//   rdata                combinational load data, 0 when not hit
//   hit                  combinational, address is TXDATA or STATUS
//   tx                   registered serial output, idle high
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_MemWr,
    input  logic        mem_MemRead,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam int          BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              tx_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    logic sel_data, sel_stat, full, empty, busy;
    logic push_req, push, pop, expire;
    logic [4:0] cnt5;
    logic unused_ok;

    // Bus decode and status mux
    assign sel_data = (mem_addr == BASE_ADDR);
    assign sel_stat = (mem_addr == STAT_ADDR);
    assign hit      = sel_data | sel_stat;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign busy  = (state_q != IDLE);
    assign cnt5  = 5'(count);

    assign rdata = sel_stat ? {24'b0, ovf, cnt5[3:0], busy, empty, full} : 32'b0;

    // A push against a full FIFO still lands if the FSM frees a slot at
    // the same edge; the write then reuses the slot being read out.
    assign push_req = mem_MemWr & sel_data;
    assign push     = push_req & (~full | pop);

    assign unused_ok = ^{mem_wdata[31:8], cnt5[4]};

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a STATUS read wins.
    always_ff @(posedge clk) begin
        if (reset)                        ovf <= 1'b0;
        else if (push_req && !push)       ovf <= 1'b1;
        else if (mem_MemRead && sel_stat) ovf <= 1'b0;
    end

    // Transmit FSM
    assign expire = (baud_q == LAST_BAUD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx      <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            state_q <= state_d;
            tx      <= tx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx;
        shift_d = shift_q;
        bit_d   = bit_q;
        // Wrapping on expiry doubles as the restart on every bit change.
        baud_d  = expire ? '0 : baud_q + 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (expire) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (expire) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    if (!empty) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shift_d = mem[rptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4).
// Accepted store bytes are queued; a serial receiver decodes tx frames and
// compares each received byte against the head of the queue.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_MemWr, mem_MemRead;
    logic [31:0] rdata;
    logic        hit, tx;

    mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_MemWr(mem_MemWr), .mem_MemRead(mem_MemRead),
        .rdata(rdata), .hit(hit), .tx(tx)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] sb[$];
    int         starts[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Serial receiver: samples mid-bit, 2 ns after each edge.
    bit         rx_act = 1'b0;
    int         rx_t   = 0;
    logic [7:0] rx_sh  = '0;
    logic [7:0] exp_b;
    always @(posedge clk) begin
        #2;
        if (reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t == 2) chk("start_mid", 32'(tx), 32'd0);
            else if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2) rx_sh = {tx, rx_sh[7:1]};
            else if (rx_t == 38) begin
                chk("stop_bit", 32'(tx), 32'd1);
                if (sb.size() == 0) chk("rx_unexpected", 32'(sb.size()), 32'd1);
                else begin
                    exp_b = sb.pop_front();
                    chk("rx_byte", 32'(rx_sh), 32'(exp_b));
                end
                rx_act = 1'b0;
            end
        end
    end

    task automatic store(input logic [31:0] d, input bit accepted);
        mem_addr  = BASE;
        mem_wdata = d;
        mem_MemWr = 1'b1;
        if (accepted) sb.push_back(d[7:0]);
        @(negedge clk);
        mem_MemWr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic h);
        mem_addr    = a;
        mem_MemRead = 1'b1;
        #1;
        v = rdata;
        h = hit;
        @(negedge clk);
        mem_MemRead = 1'b0;
        mem_addr    = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic        h;
        reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_MemWr = 1'b0; mem_MemRead = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and decode
        chk("rst_tx", 32'(tx), 32'd1);
        rd(STAT, v, h);
        chk("rst_status", v, 32'h0000_0002);
        chk("stat_hit", 32'(h), 32'd1);
        rd(BASE, v, h);
        chk("txdata_rd", v, 32'd0);
        chk("txdata_hit", 32'(h), 32'd1);
        rd(BASE + 32'd8, v, h);
        chk("miss_rd", v, 32'd0);
        chk("miss_hit", 32'(h), 32'd0);

        // Single byte: latency, start width, first data bit, busy window
        store(32'hFFFF_FFA5, 1'b1);
        chk("pre_start", 32'(tx), 32'd1);
        @(negedge clk);
        chk("start_lat", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        chk("start_end", 32'(tx), 32'd0);
        @(negedge clk);
        chk("bit0", 32'(tx), 32'd1);
        repeat (35) @(negedge clk);
        rd(STAT, v, h);
        chk("busy_t39", v, 32'h0000_0006);
        rd(STAT, v, h);
        chk("idle_t40", v, 32'h0000_0002);
        wait_drain(100);

        // Fill and overflow
        for (int i = 0; i < 9; i++) store(32'(i), 1'b1);
        store(32'h0000_0099, 1'b0);
        rd(STAT, v, h);
        chk("ovf_full", v, 32'h0000_00C5);
        rd(STAT, v, h);
        chk("ovf_clr", v, 32'h0000_0045);
        wait_drain(600);
        rd(STAT, v, h);
        chk("fill_idle", v, 32'h0000_0002);

        // Back-to-back frames
        starts.delete();
        store(32'h55, 1'b1);
        store(32'h0F, 1'b1);
        wait_drain(200);
        chk("b2b_frames", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) chk("b2b_gap", 32'(starts[1] - starts[0]), 32'd40);

        // Simultaneous push/pop on STOP expiry
        starts.delete();
        store(32'h3C, 1'b1);
        store(32'hC3, 1'b1);
        repeat (38) @(negedge clk);
        rd(STAT, v, h);
        chk("pp_before", v, 32'h0000_000C);
        store(32'h81, 1'b1);
        rd(STAT, v, h);
        chk("pp_after", v, 32'h0000_000C);
        wait_drain(300);
        chk("pp_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("pp_gap1", 32'(starts[1] - starts[0]), 32'd40);
            chk("pp_gap2", 32'(starts[2] - starts[1]), 32'd40);
        end

        // Reset during data bit 3 with two bytes still queued
        store(32'h11, 1'b1);
        store(32'h22, 1'b1);
        store(32'h33, 1'b1);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        rd(STAT, v, h);
        chk("midrst_status", v, 32'h0000_0002);
        repeat (100) @(negedge clk);
        chk("midrst_quiet", 32'(tx), 32'd1);
        rd(STAT, v, h);
        chk("midrst_end", v, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
